// File: rtl/narrow2wide_packer.sv
// Re-packs a low/high byte stream into 16-bit {hi,lo} words and queues them in a
// first-word-fall-through FIFO; flags framing errors and counts words lost to overflow.
module narrow2wide_packer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                       clk_narrow,
   input  logic                       rst_narrow_n,
   input  logic [7:0]                 byte_in,
   input  logic                       byte_valid,
   input  logic                       byte_lo,
   output logic [15:0]                word_data,
   output logic                       word_valid,
   input  logic                       word_ready,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       err_orphan,
   output logic                       err_resync,
   output logic                       overflow,
   output logic [CNT_W-1:0]           drop_cnt,
   input  logic                       drop_clr
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic {WAIT_LO, HAVE_LO} state_t;

   state_t                   state_q, state_d;
   logic [7:0]               lo_q, lo_d;
   logic [DEPTH-1:0][15:0]   mem_q;
   logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]            level_q, level_d;
   logic                     orphan_q, orphan_d;
   logic                     resync_q, resync_d;
   logic                     ovf_q, ovf_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     push, pop, accept, full;

   // Pairing FSM: only a valid high byte following a pending low byte forms a word.
   always_comb begin
      state_d  = state_q;
      lo_d     = lo_q;
      orphan_d = 1'b0;
      resync_d = 1'b0;
      push     = 1'b0;
      if (byte_valid) begin
         unique case (state_q)
            WAIT_LO: begin
               if (byte_lo) begin
                  lo_d    = byte_in;
                  state_d = HAVE_LO;
               end else begin
                  orphan_d = 1'b1;
               end
            end
            HAVE_LO: begin
               if (byte_lo) begin
                  lo_d     = byte_in;
                  resync_d = 1'b1;
               end else begin
                  push    = 1'b1;
                  state_d = WAIT_LO;
               end
            end
            default: state_d = WAIT_LO;
         endcase
      end
   end

   // A full FIFO still takes the word when the head leaves in the same cycle.
   always_comb begin
      full    = (level_q == LVL_FULL);
      pop     = (level_q != '0) && word_ready;
      accept  = push && (!full || pop);
      ovf_d   = push && full && !pop;
      level_d = level_q + LW'(accept) - LW'(pop);
      cnt_d   = cnt_q;
      if (drop_clr)
         cnt_d = '0;
      else if (ovf_d && cnt_q != CNT_MAX)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_narrow or negedge rst_narrow_n) begin
      if (!rst_narrow_n) begin
         state_q  <= WAIT_LO;
         lo_q     <= '0;
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         orphan_q <= 1'b0;
         resync_q <= 1'b0;
         ovf_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         lo_q     <= lo_d;
         level_q  <= level_d;
         orphan_q <= orphan_d;
         resync_q <= resync_d;
         ovf_q    <= ovf_d;
         cnt_q    <= cnt_d;
         if (accept) begin
            mem_q[wr_ptr_q] <= {byte_in, lo_q};
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop)
            rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   assign word_data  = mem_q[rd_ptr_q];
   assign word_valid = (level_q != '0);
   assign fifo_level = level_q;
   assign err_orphan = orphan_q;
   assign err_resync = resync_q;
   assign overflow   = ovf_q;
   assign drop_cnt   = cnt_q;

endmodule

// File: tb/tb_narrow2wide_packer.sv
// Directed bench for narrow2wide_packer: pairing, framing errors, FIFO full/overflow,
// async reset mid-stream and drop counter saturation/clear.
module tb_narrow2wide_packer;

   logic        clk_narrow = 1'b0;
   logic        rst_narrow_n;
   logic [7:0]  byte_in;
   logic        byte_valid, byte_lo, word_ready, drop_clr;
   logic [15:0] word_data;
   logic        word_valid, err_orphan, err_resync, overflow;
   logic [2:0]  fifo_level;
   logic [7:0]  drop_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   narrow2wide_packer #(.DEPTH(4), .CNT_W(8)) dut (
      .clk_narrow  (clk_narrow),
      .rst_narrow_n(rst_narrow_n),
      .byte_in     (byte_in),
      .byte_valid  (byte_valid),
      .byte_lo     (byte_lo),
      .word_data   (word_data),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .fifo_level  (fifo_level),
      .err_orphan  (err_orphan),
      .err_resync  (err_resync),
      .overflow    (overflow),
      .drop_cnt    (drop_cnt),
      .drop_clr    (drop_clr)
   );

   always #5 clk_narrow = ~clk_narrow;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are checked on the falling edge after.
   task automatic step();
      @(negedge clk_narrow);
   endtask

   task automatic put(input logic lo, input logic [7:0] b);
      byte_valid = 1'b1;
      byte_lo    = lo;
      byte_in    = b;
      step();
      byte_valid = 1'b0;
   endtask

   task automatic put_word(input logic [15:0] w);
      put(1'b1, w[7:0]);
      put(1'b0, w[15:8]);
   endtask

   initial begin
      rst_narrow_n = 1'b0;
      byte_in = '0; byte_valid = 1'b0; byte_lo = 1'b0; word_ready = 1'b0; drop_clr = 1'b0;
      step(); step();
      chk("rst_valid", {31'd0, word_valid}, 32'd0);
      chk("rst_level", {29'd0, fifo_level}, 32'd0);
      chk("rst_data", {16'd0, word_data}, 32'd0);
      chk("rst_flags", {29'd0, err_orphan, err_resync, overflow}, 32'd0);
      chk("rst_cnt", {24'd0, drop_cnt}, 32'd0);
      rst_narrow_n = 1'b1;
      step();

      // 1: simple pair with a gap cycle between halves
      word_ready = 1'b1;
      put(1'b1, 8'h34);
      chk("t1_lo_novalid", {31'd0, word_valid}, 32'd0);
      step();
      put(1'b0, 8'h12);
      chk("t1_valid", {31'd0, word_valid}, 32'd1);
      chk("t1_data", {16'd0, word_data}, 32'h1234);
      chk("t1_level1", {29'd0, fifo_level}, 32'd1);
      step();
      chk("t1_popped", {31'd0, word_valid}, 32'd0);
      chk("t1_level0", {29'd0, fifo_level}, 32'd0);

      // 2: orphan high byte
      put(1'b0, 8'hAB);
      chk("t2_orphan", {31'd0, err_orphan}, 32'd1);
      chk("t2_nopush", {29'd0, fifo_level}, 32'd0);
      put(1'b1, 8'h34);
      chk("t2_orphan_1cyc", {31'd0, err_orphan}, 32'd0);
      put(1'b0, 8'h12);
      chk("t2_data", {16'd0, word_data}, 32'h1234);
      chk("t2_level", {29'd0, fifo_level}, 32'd1);
      step();
      chk("t2_empty", {29'd0, fifo_level}, 32'd0);

      // 3: repeated low byte
      put(1'b1, 8'h11);
      put(1'b1, 8'h22);
      chk("t3_resync", {31'd0, err_resync}, 32'd1);
      put(1'b0, 8'h33);
      chk("t3_resync_1cyc", {31'd0, err_resync}, 32'd0);
      chk("t3_data", {16'd0, word_data}, 32'h3322);
      step();

      // 4: overflow with consumer stalled
      word_ready = 1'b0;
      for (int i = 1; i <= 4; i++) put_word(16'(i));
      chk("t4_full", {29'd0, fifo_level}, 32'd4);
      chk("t4_no_ovf", {31'd0, overflow}, 32'd0);
      put_word(16'h0005);
      chk("t4_ovf", {31'd0, overflow}, 32'd1);
      chk("t4_level", {29'd0, fifo_level}, 32'd4);
      chk("t4_cnt", {24'd0, drop_cnt}, 32'd1);
      chk("t4_head_hold", {16'd0, word_data}, 32'h0001);
      step();
      chk("t4_ovf_1cyc", {31'd0, overflow}, 32'd0);
      word_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("t4_drain%0d", i), {16'd0, word_data}, 32'(i));
         step();
      end
      chk("t4_drained", {31'd0, word_valid}, 32'd0);

      // 5: push coincident with pop while full
      word_ready = 1'b0;
      for (int i = 0; i < 4; i++) put_word(16'h0010 + 16'(i));
      put(1'b1, 8'h14);
      word_ready = 1'b1;
      put(1'b0, 8'h00);
      chk("t5_no_ovf", {31'd0, overflow}, 32'd0);
      chk("t5_level", {29'd0, fifo_level}, 32'd4);
      chk("t5_cnt", {24'd0, drop_cnt}, 32'd1);
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("t5_drain%0d", i), {16'd0, word_data}, 32'h10 + 32'(i));
         step();
      end
      chk("t5_empty", {29'd0, fifo_level}, 32'd0);

      // 6: async reset mid-stream, then counter saturation and clear priority
      word_ready = 1'b0;
      put_word(16'hA1A2);
      put_word(16'hB1B2);
      put(1'b1, 8'hC3);
      chk("t6_pre_level", {29'd0, fifo_level}, 32'd2);
      #2 rst_narrow_n = 1'b0;
      #1;
      chk("t6_rst_valid", {31'd0, word_valid}, 32'd0);
      chk("t6_rst_level", {29'd0, fifo_level}, 32'd0);
      chk("t6_rst_data", {16'd0, word_data}, 32'd0);
      chk("t6_rst_cnt", {24'd0, drop_cnt}, 32'd0);
      step();
      rst_narrow_n = 1'b1;
      step();
      put(1'b0, 8'hD4);
      chk("t6_orphan", {31'd0, err_orphan}, 32'd1);
      chk("t6_nopush", {29'd0, fifo_level}, 32'd0);
      for (int i = 0; i < 4; i++) put_word(16'h0100 + 16'(i));
      for (int i = 0; i < 254; i++) put_word(16'hEE00);
      chk("t6_cnt254", {24'd0, drop_cnt}, 32'd254);
      put_word(16'hEE01);
      chk("t6_cnt255", {24'd0, drop_cnt}, 32'd255);
      put_word(16'hEE02);
      chk("t6_sat", {24'd0, drop_cnt}, 32'd255);
      chk("t6_sat_ovf", {31'd0, overflow}, 32'd1);
      put(1'b1, 8'h55);
      drop_clr = 1'b1;
      put(1'b0, 8'h66);
      drop_clr = 1'b0;
      chk("t6_clr_ovf", {31'd0, overflow}, 32'd1);
      chk("t6_clr_cnt", {24'd0, drop_cnt}, 32'd0);
      chk("t6_head", {16'd0, word_data}, 32'h0100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
